sys_arr_ctrl: RTL
=================

Name: sys_arr_ctrl

Overview:
Sequencer for the WIDTH_HEIGHT x WIDTH_HEIGHT systolic array. On a start pulse it preloads one weight tile into the array, streams the input vectors into it, and issues output-buffer writes as results emerge from the array.
It owns the array's wwrite and active controls and the read/write addresses of the weight, data and output buffers. It never touches the datapath buses.

Parameters:
WIDTH_HEIGHT, 4, array dimension; number of weight rows loaded.
ADDR_WIDTH, 8, buffer address width.
ROWS_WIDTH, 8, width of num_rows.
ARR_LATENCY, 7, cycles from active asserted on a vector to its result being valid on maccout (2*WIDTH_HEIGHT-1).

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  single-cycle request; sampled only in IDLE.
num_rows  in  ROWS_WIDTH  input vectors to process; latched on start.
weight_base  in  ADDR_WIDTH  first weight-buffer address; latched on start.
data_base  in  ADDR_WIDTH  first data-buffer address; latched on start.
out_base  in  ADDR_WIDTH  first output-buffer address; latched on start.
weight_ren  out  1  weight-buffer read enable.
weight_raddr  out  ADDR_WIDTH  weight-buffer read address.
wwrite  out  WIDTH_HEIGHT  array weight-write enables; all bits equal.
data_ren  out  1  data-buffer read enable.
data_raddr  out  ADDR_WIDTH  data-buffer read address.
active  out  1  array active.
out_wen  out  1  output-buffer write enable.
out_waddr  out  ADDR_WIDTH  output-buffer write address.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered. Reset drives every output to 0, forces the state to IDLE and clears the internal delay pipelines. Reset takes effect at the next edge, including mid-operation.
- Buffers have a 1-cycle read latency. Array controls are therefore the read enables delayed by one cycle:
  - wwrite = {WIDTH_HEIGHT{weight_ren}} delayed 1 cycle.
  - active = data_ren delayed 1 cycle.
  - out_wen = data_ren delayed 1+ARR_LATENCY cycles, implemented as a shift register.
- FSM states: IDLE, LOAD_W, FEED, DRAIN.
- IDLE:
  - start with num_rows != 0: latch inputs, go to LOAD_W.
  - start with num_rows == 0: done=1 next cycle, stay in IDLE, no buffer activity.
- LOAD_W: exactly WIDTH_HEIGHT cycles. weight_ren=1, weight_raddr = weight_base+k for k = 0..WIDTH_HEIGHT-1. Then go to FEED.
- FEED: exactly F = num_rows+WIDTH_HEIGHT-1 cycles, which covers skewed input vectors. data_ren=1, data_raddr = data_base+j for j = 0..F-1. Then go to DRAIN.
- DRAIN: waits until the last out_wen has been issued. Each out_wen pulse writes to out_waddr = out_base+m (m = 0..F-1); the address increments after each write.
- Completion: done pulses in the cycle after the final out_wen. busy falls in that same cycle and the FSM enters IDLE.
- Counter widths: F is computed at ROWS_WIDTH+1 bits so that no overflow occurs. Addresses wrap modulo 2^ADDR_WIDTH.
- Ordering and back-to-back use: LOAD_W and FEED are back-to-back with no gap cycle. A new start is accepted in the cycle immediately after done.
- start while busy is ignored. Latched parameters do not change mid-operation.

Optional Feature:
SYS_ARR_CTRL_WREUSE_EN:
- Defined: adds input port reuse_weights (1 bit), sampled with start. When it is 1, the FSM goes IDLE->FEED directly, skipping LOAD_W; weight_ren and wwrite stay 0 for that operation.
- Undefined: port is absent and every operation loads weights.

Test Plan:
- Reset, then start (num_rows=4, weight_base=0x10) at cycle 0 -> weight_ren cycles 1-4 with addresses 0x10,0x11,0x12,0x13; wwrite=4'b1111 cycles 2-5.
- Same run, data_base=0x20 -> data_ren cycles 5-11 with addresses 0x20..0x26; active=1 cycles 6-12.
- Same run, out_base=0x40 -> out_wen cycles 13-19 with addresses 0x40..0x46; done=1 at cycle 20; busy high cycles 1-19.
- num_rows=0 start -> done=1 next cycle only; no ren/wen ever asserted; busy stays 0. Start pulsed again during FEED -> ignored; total out_wen count unchanged.
- data_base=0xFE, num_rows=2 -> data_raddr 0xFE,0xFF,0x00,0x01,0x02. Reset asserted mid-FEED -> all outputs 0 next cycle; a fresh start then completes normally.
- With SYS_ARR_CTRL_WREUSE_EN defined, reuse_weights=1, num_rows=4 -> no weight_ren; data_ren begins cycle 1; done at cycle 16.

Source files
------------

// File: rtl/sys_arr_ctrl.sv
// Sequencer for a WIDTH_HEIGHT x WIDTH_HEIGHT systolic array: weight preload, input feed, output drain.
// Optional weight reuse (skip LOAD_W) is enabled by defining SYS_ARR_CTRL_WREUSE_EN.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_W | reading WIDTH_HEIGHT weight rows into the array
// FEED   | streaming num_rows+WIDTH_HEIGHT-1 skewed input vectors
// DRAIN  | waiting for the last output-buffer write
module sys_arr_ctrl #(
  parameter int WIDTH_HEIGHT = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int ROWS_WIDTH   = 8,
  parameter int ARR_LATENCY  = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
`ifdef SYS_ARR_CTRL_WREUSE_EN
  input  logic                    reuse_weights,
`endif
  input  logic [ROWS_WIDTH-1:0]   num_rows,
  input  logic [ADDR_WIDTH-1:0]   weight_base,
  input  logic [ADDR_WIDTH-1:0]   data_base,
  input  logic [ADDR_WIDTH-1:0]   out_base,
  output logic                    weight_ren,
  output logic [ADDR_WIDTH-1:0]   weight_raddr,
  output logic [WIDTH_HEIGHT-1:0] wwrite,
  output logic                    data_ren,
  output logic [ADDR_WIDTH-1:0]   data_raddr,
  output logic                    active,
  output logic                    out_wen,
  output logic [ADDR_WIDTH-1:0]   out_waddr,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = ROWS_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, LOAD_W, FEED, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       feed_last;
  logic [ROWS_WIDTH-1:0]  num_rows_q, num_rows_d;
  logic [ADDR_WIDTH-1:0]  data_base_q, data_base_d;
  logic                   weight_ren_q, weight_ren_d;
  logic [ADDR_WIDTH-1:0]  weight_raddr_q, weight_raddr_d;
  logic                   wwrite_q, wwrite_d;
  logic                   data_ren_q, data_ren_d;
  logic [ADDR_WIDTH-1:0]  data_raddr_q, data_raddr_d;
  logic [ARR_LATENCY-1:0] pipe_q, pipe_d;
  logic                   out_wen_q, out_wen_d;
  logic [ADDR_WIDTH-1:0]  out_waddr_q, out_waddr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   reuse_sel;

`ifdef SYS_ARR_CTRL_WREUSE_EN
  assign reuse_sel = reuse_weights;
`else
  assign reuse_sel = 1'b0;
`endif

  // Last feed index F-1 = num_rows + WIDTH_HEIGHT - 2, one bit wider than num_rows.
  assign feed_last = {1'b0, num_rows_q} + CNT_W'(WIDTH_HEIGHT - 2);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    num_rows_d     = num_rows_q;
    data_base_d    = data_base_q;
    weight_ren_d   = 1'b0;
    weight_raddr_d = weight_raddr_q;
    data_ren_d     = 1'b0;
    data_raddr_d   = data_raddr_q;
    done_d         = 1'b0;
    wwrite_d       = weight_ren_q;
    pipe_d         = {pipe_q[ARR_LATENCY-2:0], data_ren_q};
    out_wen_d      = pipe_q[ARR_LATENCY-1];
    out_waddr_d    = out_wen_q ? out_waddr_q + ADDR_WIDTH'(1) : out_waddr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_rows == '0) begin
            done_d = 1'b1;
          end else begin
            num_rows_d  = num_rows;
            data_base_d = data_base;
            out_waddr_d = out_base;
            cnt_d       = '0;
            if (reuse_sel) begin
              state_d      = FEED;
              data_ren_d   = 1'b1;
              data_raddr_d = data_base;
            end else begin
              state_d        = LOAD_W;
              weight_ren_d   = 1'b1;
              weight_raddr_d = weight_base;
            end
          end
        end
      end
      LOAD_W: begin
        if (cnt_q == CNT_W'(WIDTH_HEIGHT - 1)) begin
          state_d      = FEED;
          cnt_d        = '0;
          data_ren_d   = 1'b1;
          data_raddr_d = data_base_q;
        end else begin
          cnt_d          = cnt_q + CNT_W'(1);
          weight_ren_d   = 1'b1;
          weight_raddr_d = weight_raddr_q + ADDR_WIDTH'(1);
        end
      end
      FEED: begin
        if (cnt_q == feed_last) begin
          state_d = DRAIN;
        end else begin
          cnt_d        = cnt_q + CNT_W'(1);
          data_ren_d   = 1'b1;
          data_raddr_d = data_raddr_q + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        // Final write is on the bus and nothing remains in flight.
        if (out_wen_q && (pipe_q == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      num_rows_q     <= '0;
      data_base_q    <= '0;
      weight_ren_q   <= 1'b0;
      weight_raddr_q <= '0;
      wwrite_q       <= 1'b0;
      data_ren_q     <= 1'b0;
      data_raddr_q   <= '0;
      pipe_q         <= '0;
      out_wen_q      <= 1'b0;
      out_waddr_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      num_rows_q     <= num_rows_d;
      data_base_q    <= data_base_d;
      weight_ren_q   <= weight_ren_d;
      weight_raddr_q <= weight_raddr_d;
      wwrite_q       <= wwrite_d;
      data_ren_q     <= data_ren_d;
      data_raddr_q   <= data_raddr_d;
      pipe_q         <= pipe_d;
      out_wen_q      <= out_wen_d;
      out_waddr_q    <= out_waddr_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign weight_ren   = weight_ren_q;
  assign weight_raddr = weight_raddr_q;
  assign wwrite       = {WIDTH_HEIGHT{wwrite_q}};
  assign data_ren     = data_ren_q;
  assign data_raddr   = data_raddr_q;
  assign active       = pipe_q[0];
  assign out_wen      = out_wen_q;
  assign out_waddr    = out_waddr_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
